// File: rtl/riscv_pkg.sv
// Shared types for the RV32I pipeline hazard logic: forward select codes,
// shadow-pipeline stage tags and the forwarding priority helper.
package riscv_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       is_load;
  } stage_tag_t;

  // Snapshot of the whole shadow pipeline, exported for observation.
  typedef struct packed {
    stage_tag_t e;
    stage_tag_t m;
    stage_tag_t w;
    logic [4:0] rs1_e;
    logic [4:0] rs2_e;
  } shadow_t;

  // Select for an operand about to enter E: the youngest writer wins.
  function automatic fwd_sel_t fwd_pick(stage_tag_t e, stage_tag_t m, logic [4:0] src);
    if (e.reg_write && (e.rd != 5'd0) && (e.rd == src)) return FWD_M;
    if (m.reg_write && (m.rd != 5'd0) && (m.rd == src)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_scheduler.sv
// Hazard controller for the five-stage RV32I core: shadow E/M/W tags drive
// registered forward selects, load-use stalls, redirect flushes and counters.
module hazard_scheduler
  import riscv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_d,
  input  logic             reg_write_d,
  input  logic [1:0]       result_src_d,
  input  logic             pc_src_e,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output shadow_t          dbg_shadow_o
);

  stage_tag_t tag_e_q, tag_e_d, tag_m_q, tag_w_q;
  logic [4:0] rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d;
  fwd_sel_t   fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic       lw_stall;

  assign lw_stall = tag_e_q.is_load & tag_e_q.reg_write & (tag_e_q.rd != 5'd0) &
                    ((tag_e_q.rd == rs1_d) | (tag_e_q.rd == rs2_d));

  // Controls are masked during reset so a floating pc_src_e cannot leak out.
  assign flush_d = pc_src_e & ~srst;
  assign flush_e = (pc_src_e | lw_stall) & ~srst;
  assign stall_f = lw_stall & ~pc_src_e & ~srst;
  assign stall_d = stall_f;

  always_comb begin
    tag_e_d = '0;
    rs1_e_d = '0;
    rs2_e_d = '0;
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (!flush_e) begin
      tag_e_d.rd        = rd_d;
      tag_e_d.reg_write = reg_write_d;
      tag_e_d.is_load   = (result_src_d == RESULT_SRC_LOAD);
      rs1_e_d           = rs1_d;
      rs2_e_d           = rs2_d;
      fwd_a_d           = fwd_pick(tag_e_q, tag_m_q, rs1_d);
      fwd_b_d           = fwd_pick(tag_e_q, tag_m_q, rs2_d);
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      tag_e_q <= '0;
      tag_m_q <= '0;
      tag_w_q <= '0;
      rs1_e_q <= '0;
      rs2_e_q <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      tag_w_q <= tag_m_q;
      tag_m_q <= tag_e_q;
      tag_e_q <= tag_e_d;
      rs1_e_q <= rs1_e_d;
      rs2_e_q <= rs2_e_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign forward_a_e = fwd_a_q;
  assign forward_b_e = fwd_b_q;

  assign dbg_shadow_o = '{e: tag_e_q, m: tag_m_q, w: tag_w_q, rs1_e: rs1_e_q, rs2_e: rs2_e_q};

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk),
    .rst_i   (srst),
    .inc_i   (stall_d),
    .count_o (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i   (clk),
    .rst_i   (srst),
    .inc_i   (flush_d),
    .count_o (flush_count)
  );

endmodule

// File: doc/hazard_scheduler.md
# hazard_scheduler

Pipeline hazard controller for the five-stage RV32I core. It sits beside the decode/execute stage registers and tracks the destination tags of the instructions in E, M and W in its own shadow pipeline. From those tags it generates registered forwarding selects for the execute-stage ALU operands, load-use stalls for F/D, and flushes for D/E on taken branches or jumps. It also keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of each saturating event counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- srst  in  1  reset, asynchronous, active-high.
- rs1_d  in  5  rs1 field of the instruction in D.
- rs2_d  in  5  rs2 field of the instruction in D.
- rd_d  in  5  rd field of the instruction in D.
- reg_write_d  in  1  D instruction writes the register file.
- result_src_d  in  2  D result source; 2'b01 = load.
- pc_src_e  in  1  taken branch/jump resolved in E.
- forward_a_e  out  2  ALU operand A select for the instruction in E.
- forward_b_e  out  2  ALU operand B select for the instruction in E.
- stall_f  out  1  hold the PC register.
- stall_d  out  1  hold the fetch/decode register.
- flush_d  out  1  clear the fetch/decode register.
- flush_e  out  1  clear the decode/execute register.
- stall_count  out  CNT_W  load-use stall cycles, saturating.
- flush_count  out  CNT_W  taken-redirect events, saturating.

## Operation
- Shadow tags: per stage S in {E, M, W}, hold rd_S, reg_write_S, is_load_S. E also holds rs1_e and rs2_e.
- Per clock: W tag <= M tag; M tag <= E tag; E tag <= bubble (all zero) if flush_e, else the D fields. is_load_d = (result_src_d == 2'b01).
- Forward select codes: FWD_RF = 00 (register file), FWD_W = 01, FWD_M = 10. Code 11 is never driven.
- Next forward_a_e, computed for the instruction entering E:
  - 10 if reg_write_e, rd_e != 0 and rd_e == rs1_d (the producer moves to M).
  - Otherwise 01 if reg_write_m, rd_m != 0 and rd_m == rs1_d (the producer moves to W).
  - Otherwise 00.
  - M has priority over W.
- forward_b_e is computed the same way using rs2_d.
- If flush_e, both forward selects load 00.
- Load-use: lw_stall = is_load_e & reg_write_e & (rd_e != 0) & (rd_e == rs1_d | rd_e == rs2_d). Both sources are compared unconditionally; spurious stalls on unused fields are accepted.
- Redirect: flush_d = pc_src_e; flush_e = pc_src_e | lw_stall.
- stall_f = stall_d = lw_stall & ~pc_src_e. A redirect kills D, so there is no stall in that case.
- Register-file write-then-read in the same cycle is resolved by the register file (negedge write). This block has no D-stage bypass.
- Counters: stall_count increments on cycles with stall_d = 1. flush_count increments on cycles with pc_src_e = 1. Each holds at 2^CNT_W-1.

## Timing
- Reset (srst high, async):
  - All tags cleared.
  - forward_a_e = forward_b_e = 00.
  - Both counters 0.
  - stall_f, stall_d, flush_d and flush_e are forced to 0 while srst is high, regardless of pc_src_e.
- forward_*_e: registered, valid in the same cycle the instruction is in E; 1-cycle latency from D inputs.
- stall/flush: combinational from the E tag and the D/E inputs, valid within the same cycle.
- A load-use stall lasts exactly one cycle:
  - The next cycle has a bubble in E.
  - The load is in M, so lw_stall = 0.
  - The held D instruction re-evaluates and gets forward select 01.
- pc_src_e together with lw_stall: flush_d = flush_e = 1, no stall, stall_count unchanged, flush_count +1.
- Reset deasserted mid-stall: the first cycle after release behaves as for an empty pipeline.

## Structure
- riscv_pkg holds:
  - fwd_sel_t enum {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10}.
  - RESULT_SRC_LOAD = 2'b01.
  - stage_tag_t struct {rd, reg_write, is_load}.
- Sub-module sat_counter #(W) (inc, count, async reset). It is instantiated twice, once per counter.

## Test plan
- add x5 (E), D add x6,x5,x1 -> next cycle forward_a_e=10, forward_b_e=00, no stall.
- add x5 (M), D sub x6,x2,x5 -> next cycle forward_b_e=01.
- x5 written by both the E and M instructions, D uses rs1 = x5 -> forward_a_e=10 (M priority over W).
- lw x7 (E), D add x8,x1,x7:
  - Stall cycle: stall_f=stall_d=flush_e=1, flush_d=0.
  - Next cycle: E holds the bubble, forward_b_e=00, no stall.
  - Cycle after (add in E, lw in W): forward_b_e=01.
  - stall_count=1.
- rd = x0 writers in E and M, D uses x0 -> forward selects stay 00; lw x0 causes no stall.
- pc_src_e=1 in the same cycle as a load-use hazard -> flush_d=flush_e=1, stall_f=0, flush_count=1, stall_count=0.
- With CNT_W=2: 5 consecutive load-use stalls -> stall_count saturates at 3.
- srst asserted asynchronously mid-stall -> all outputs 0 before the next clock edge.
